// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, FSM states,
// datapath select codes and the bundle of control strobes.
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_R,
        ST_EXEC_I,
        ST_ADDR,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_WB_ALU,
        ST_WB_MEM,
        ST_BRANCH,
        ST_JAL,
        ST_JALR,
        ST_UPPER,
        ST_TRAP
    } state_e;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;
    localparam logic [1:0] WB_IMM    = 2'b11;

    localparam logic [1:0] SRC_A_RS1    = 2'b00;
    localparam logic [1:0] SRC_A_PC     = 2'b01;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_src;
    } ctrl_t;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation: funct3 plus ALU flags give taken, or flag an
// encoding this configuration does not support.
module branch_cond #(
    parameter int EXT_OPS = 1
) (
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       taken,
    output logic       illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = ltu;
            3'b111:  taken = ~ltu;
            default: illegal = 1'b1;
        endcase
        // Reduced configuration only knows BEQ.
        if (EXT_OPS == 0 && funct3 != 3'b000) begin
            taken   = 1'b0;
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// times out stalled memory accesses and counts retired instructions.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// FETCH     | read instruction at PC, load IR and PC+4 on mem_ready
// DECODE    | ALUOut <- old_pc + imm, dispatch on opcode
// EXEC_R/I  | funct-decoded ALU op on rs1 and rs2/imm
// ADDR      | ALUOut <- rs1 + imm for load/store
// MEM_RD/WR | data access at ALUOut, wait for mem_ready
// WB_ALU/MEM| register write from ALUOut / MDR
// BRANCH    | compare rs1/rs2, PC <- ALUOut when taken
// JAL/JALR  | link write plus jump
// UPPER     | LUI / AUIPC writeback
// TRAP      | sticky fault, everything idle until reset
module multicycle_control
    import rv_ctrl_pkg::*;
#(
    parameter int EXT_OPS     = 1,
    parameter int MEM_TIMEOUT = 15,
    parameter int RET_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             mem_ready,
    input  logic             zero,
    input  logic             lt,
    input  logic             ltu,
    output logic             ir_write,
    output logic             pc_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             pc_src,
    output logic [1:0]       fault,
    output logic [RET_W-1:0] instret
);

    localparam bit EXT_EN = (EXT_OPS != 0);
    localparam int CNT_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic [1:0]         fault_q, fault_d;
    logic [RET_W-1:0]   instret_q, instret_d;
    logic               br_taken, br_illegal;
    logic               wait_state, timeout_hit;
    ctrl_t              ctl, ctl_out;

    branch_cond #(.EXT_OPS(EXT_OPS)) u_branch_cond (
        .funct3  (funct3),
        .zero    (zero),
        .lt      (lt),
        .ltu     (ltu),
        .taken   (br_taken),
        .illegal (br_illegal)
    );

    // wait_q holds the waits already seen, so this cycle is the last allowed one.
    assign timeout_hit = (MEM_TIMEOUT > 0) && (wait_q == WAIT_LAST);

    always_comb begin
        state_d    = state_q;
        fault_d    = fault_q;
        ctl        = '0;
        wait_state = 1'b0;
        case (state_q)
            ST_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_a = SRC_A_PC;
                ctl.alu_src_b = SRC_B_FOUR;
                wait_state    = 1'b1;
                if (mem_ready) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    state_d      = ST_DECODE;
                end else if (timeout_hit) begin
                    state_d = ST_TRAP;
                    fault_d = FAULT_TIMEOUT;
                end
            end
            ST_DECODE: begin
                ctl.alu_src_a = SRC_A_OLD_PC;
                ctl.alu_src_b = SRC_B_IMM;
                ctl.alu_op    = ALU_ADD;
                state_d       = ST_TRAP;
                fault_d       = FAULT_ILLEGAL;
                case (opcode)
                    OPC_R:                state_d = ST_EXEC_R;
                    OPC_I:                state_d = ST_EXEC_I;
                    OPC_LOAD, OPC_STORE:  state_d = ST_ADDR;
                    OPC_BRANCH:           state_d = ST_BRANCH;
                    OPC_JAL:              if (EXT_EN) state_d = ST_JAL;
                    OPC_JALR:             if (EXT_EN) state_d = ST_JALR;
                    OPC_LUI, OPC_AUIPC:   if (EXT_EN) state_d = ST_UPPER;
                    default:              state_d = ST_TRAP;
                endcase
                if (state_d != ST_TRAP) begin
                    fault_d = fault_q;
                end
            end
            ST_EXEC_R: begin
                ctl.alu_src_a = SRC_A_RS1;
                ctl.alu_src_b = SRC_B_RS2;
                ctl.alu_op    = ALU_FUNCT;
                state_d       = ST_WB_ALU;
            end
            ST_EXEC_I: begin
                ctl.alu_src_a = SRC_A_RS1;
                ctl.alu_src_b = SRC_B_IMM;
                ctl.alu_op    = ALU_FUNCT;
                state_d       = ST_WB_ALU;
            end
            ST_ADDR: begin
                ctl.alu_src_a = SRC_A_RS1;
                ctl.alu_src_b = SRC_B_IMM;
                ctl.alu_op    = ALU_ADD;
                state_d       = (opcode == OPC_LOAD) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD, ST_MEM_WR: begin
                ctl.mem_read  = (state_q == ST_MEM_RD);
                ctl.mem_write = (state_q == ST_MEM_WR);
                ctl.iord      = 1'b1;
                wait_state    = 1'b1;
                if (mem_ready) begin
                    state_d = (state_q == ST_MEM_RD) ? ST_WB_MEM : ST_FETCH;
                end else if (timeout_hit) begin
                    state_d = ST_TRAP;
                    fault_d = FAULT_TIMEOUT;
                end
            end
            ST_WB_ALU: begin
                ctl.reg_write = 1'b1;
                ctl.wb_sel    = WB_ALUOUT;
                state_d       = ST_FETCH;
            end
            ST_WB_MEM: begin
                ctl.reg_write = 1'b1;
                ctl.wb_sel    = WB_MDR;
                state_d       = ST_FETCH;
            end
            ST_BRANCH: begin
                ctl.alu_src_a = SRC_A_RS1;
                ctl.alu_src_b = SRC_B_RS2;
                ctl.alu_op    = ALU_SUB;
                ctl.pc_src    = 1'b1;
                ctl.pc_write  = br_taken;
                if (br_illegal) begin
                    state_d = ST_TRAP;
                    fault_d = FAULT_ILLEGAL;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_JAL: begin
                ctl.reg_write = 1'b1;
                ctl.wb_sel    = WB_PC;
                ctl.pc_write  = 1'b1;
                ctl.pc_src    = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_JALR: begin
                ctl.reg_write = 1'b1;
                ctl.wb_sel    = WB_PC;
                ctl.alu_src_a = SRC_A_RS1;
                ctl.alu_src_b = SRC_B_IMM;
                ctl.pc_write  = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_UPPER: begin
                // AUIPC reuses old_pc + imm already sitting in ALUOut from DECODE.
                ctl.reg_write = 1'b1;
                ctl.wb_sel    = (opcode == OPC_LUI) ? WB_IMM : WB_ALUOUT;
                state_d       = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_comb begin
        wait_d    = wait_q;
        instret_d = instret_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (wait_state && !mem_ready && MEM_TIMEOUT > 0) begin
            wait_d = wait_q + CNT_W'(1);
        end
        if (state_d == ST_FETCH && state_q != ST_FETCH && state_q != ST_TRAP) begin
            instret_d = instret_q + RET_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            wait_q    <= '0;
            fault_q   <= FAULT_NONE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            fault_q   <= fault_d;
            instret_q <= instret_d;
        end
    end

    // FETCH decodes to mem_read=1, so strobes are masked while reset is held.
    assign ctl_out   = rst ? '0 : ctl;
    assign ir_write  = ctl_out.ir_write;
    assign pc_write  = ctl_out.pc_write;
    assign mem_read  = ctl_out.mem_read;
    assign mem_write = ctl_out.mem_write;
    assign iord      = ctl_out.iord;
    assign reg_write = ctl_out.reg_write;
    assign wb_sel    = ctl_out.wb_sel;
    assign alu_src_a = ctl_out.alu_src_a;
    assign alu_src_b = ctl_out.alu_src_b;
    assign alu_op    = ctl_out.alu_op;
    assign pc_src    = ctl_out.pc_src;
    assign fault     = fault_q;
    assign instret   = instret_q;

endmodule
